// File: rtl/in_fifo_rd_sched_if.sv
// Handshake and data bundle between the IN_FIFO read scheduler, the PHY input
// FIFO (flags, Q, RDEN) and the downstream capture logic (valid/ready stream).
interface in_fifo_rd_sched_if #(
    parameter int DATA_WIDTH = 80
);
    logic                  fifo_empty;
    logic                  fifo_almostempty;
    logic [DATA_WIDTH-1:0] fifo_q;
    logic                  fifo_rden;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  flush;
    logic                  busy;
    logic [15:0]           rd_count;

    // Scheduler side
    modport master (
        input  fifo_empty,
        input  fifo_almostempty,
        input  fifo_q,
        input  m_ready,
        input  flush,
        output fifo_rden,
        output m_valid,
        output m_data,
        output busy,
        output rd_count
    );

    // Environment side: FIFO model plus downstream consumer
    modport slave (
        output fifo_empty,
        output fifo_almostempty,
        output fifo_q,
        output m_ready,
        output flush,
        input  fifo_rden,
        input  m_valid,
        input  m_data,
        input  busy,
        input  rd_count
    );
endinterface

// File: rtl/in_fifo_rd_sched.sv
// Read-side scheduler for the IN_FIFO in synchronous mode. Reads are issued
// against EMPTY/ALMOSTEMPTY and limited by credits so that every read that is
// in flight is guaranteed a slot in the skid buffer when its Q word lands.
module in_fifo_rd_sched #(
    parameter int DATA_WIDTH  = 80,
    parameter int RD_LATENCY  = 1,
    parameter int INIT_CYCLES = 4
) (
    input logic                clk,
    input logic                rst,
    in_fifo_rd_sched_if.master bus
);

    localparam int DEPTH = RD_LATENCY + 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = $clog2(DEPTH);

    typedef enum logic [1:0] {
        INIT,
        RUN,
        FL_WAIT,
        FL_DRAIN
    } state_t;

    state_t                state;
    state_t                state_n;
    logic [3:0]            init_cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         occupancy;
    logic [CW-1:0]         in_flight;
    logic [CW-1:0]         credit;
    logic                  rden;
    logic                  rden_q;
    logic                  issue_d1;
    logic                  land;
    logic                  push;
    logic                  pop;
    logic                  flush_take;
    logic                  valid;
    logic [15:0]           rd_count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign credit = occupancy + in_flight;
    assign valid  = (occupancy != '0);
    assign pop    = valid && bus.m_ready;
    assign push   = land && (state == RUN) && !flush_take;

    // Next-state selection and the combinational read enable for each state
    always_comb begin
        state_n    = state;
        rden       = 1'b0;
        flush_take = 1'b0;
        case (state)
            INIT: begin
                if (bus.flush) begin
                    flush_take = 1'b1;
                    state_n    = FL_WAIT;
                end else if (init_cnt == 4'(INIT_CYCLES - 1)) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                rden = !bus.fifo_empty && (credit < CW'(DEPTH)) &&
                       !(bus.fifo_almostempty && rden_q);
                if (bus.flush) begin
                    flush_take = 1'b1;
                    state_n    = FL_WAIT;
                end
            end
            FL_WAIT: begin
                if (in_flight == '0) begin
                    state_n = FL_DRAIN;
                end
            end
            FL_DRAIN: begin
                rden = !bus.fifo_empty && !(bus.fifo_almostempty && rden_q);
                if (bus.fifo_empty && (in_flight == '0) && !rden_q) begin
                    state_n = RUN;
                end
            end
            default: state_n = INIT;
        endcase
    end

    // State register and the post-reset settling counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state <= state_n;
            if (state == INIT) begin
                init_cnt <= init_cnt + 4'd1;
            end
        end
    end

    // Track reads in flight and remember last cycle's enable for the ALMOSTEMPTY rule
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rden_q    <= 1'b0;
            issue_d1  <= 1'b0;
            in_flight <= '0;
        end else begin
            rden_q    <= rden;
            issue_d1  <= rden;
            in_flight <= in_flight + CW'(rden) - CW'(land);
        end
    end

    generate
        if (RD_LATENCY == 1) begin : g_lat1
            assign land = issue_d1;
        end else begin : g_lat2
            logic issue_d2;

            // Second delay stage so the landing strobe lines up with a two-cycle Q
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    issue_d2 <= 1'b0;
                end else begin
                    issue_d2 <= issue_d1;
                end
            end

            assign land = issue_d2;
        end
    endgenerate

    // Circular skid buffer; a flush empties it at once and landing words are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush_take) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.fifo_q;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            occupancy <= occupancy + CW'(push) - CW'(pop);
        end
    end

    // Count accepted words; deliberately untouched by flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count <= '0;
        end else if (pop) begin
            rd_count <= rd_count + 16'd1;
        end
    end

    assign bus.fifo_rden = rden;
    assign bus.m_valid   = valid;
    assign bus.m_data    = mem[rd_ptr];
    assign bus.busy      = (state != RUN);
    assign bus.rd_count  = rd_count;

endmodule

// File: tb/tb_in_fifo_rd_sched.sv
// Directed bench for in_fifo_rd_sched: a queue-based IN_FIFO model with
// one-cycle Q latency feeds the scheduler; expected values are hand-derived.
module tb_in_fifo_rd_sched;

    localparam int DW = 80;

    logic clk = 1'b0;
    logic rst = 1'b1;

    in_fifo_rd_sched_if #(.DATA_WIDTH(DW)) bus ();

    in_fifo_rd_sched #(
        .DATA_WIDTH (DW),
        .RD_LATENCY (1),
        .INIT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fifo_mem [$];
    logic [DW-1:0] fifo_q_r  = '0;
    int            fifo_cnt  = 0;
    int            rd_issued = 0;
    int            bad_reads = 0;
    int            adj_reads = 0;
    logic          prev_rden = 1'b0;
    int            pass_cnt  = 0;
    int            total_cnt = 0;
    int            base;
    int            adj_base;

    assign bus.fifo_empty = (fifo_cnt == 0);
    assign bus.fifo_q     = fifo_q_r;

    // FIFO model: a read sampled at an edge presents its word on Q one cycle later
    always @(posedge clk) begin
        prev_rden <= bus.fifo_rden;
        if (bus.fifo_rden) begin
            rd_issued++;
            if (prev_rden) adj_reads++;
            if (fifo_cnt > 0) begin
                fifo_q_r <= fifo_mem.pop_front();
                fifo_cnt <= fifo_cnt - 1;
            end else begin
                bad_reads++;
            end
        end
    end

    function automatic logic [DW-1:0] w(input logic [7:0] b);
        return {{(DW-8){1'b0}}, b};
    endfunction

    task automatic push(input logic [DW-1:0] d);
        fifo_mem.push_back(d);
        fifo_cnt = fifo_cnt + 1;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [DW-1:0] observed,
                                input logic [DW-1:0] expected);
        total_cnt++;
        assert (observed === expected) pass_cnt++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    initial begin
        bus.fifo_almostempty = 1'b0;
        bus.m_ready          = 1'b0;
        bus.flush            = 1'b0;
        repeat (2) tick();

        // Reset values
        check_output("rst_rden", DW'(bus.fifo_rden), 0);
        check_output("rst_valid", DW'(bus.m_valid), 0);
        check_output("rst_data", bus.m_data, 0);
        check_output("rst_busy", DW'(bus.busy), 1);
        check_output("rst_count", DW'(bus.rd_count), 0);

        // INIT settling then streaming of 8 words
        for (int i = 1; i <= 8; i++) push(w(8'(i)));
        bus.m_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("init_rden_c1", DW'(bus.fifo_rden), 0);
        check_output("init_busy_c1", DW'(bus.busy), 1);
        for (int c = 2; c <= 4; c++) begin
            tick();
            check_output("init_rden", DW'(bus.fifo_rden), 0);
        end
        tick();
        check_output("first_rden_c5", DW'(bus.fifo_rden), 1);
        check_output("busy_low_c5", DW'(bus.busy), 0);
        check_output("valid_c5", DW'(bus.m_valid), 0);
        tick();
        check_output("valid_c6", DW'(bus.m_valid), 0);
        tick();
        for (int i = 1; i <= 8; i++) begin
            check_output("stream_valid", DW'(bus.m_valid), 1);
            check_output("stream_data", bus.m_data, w(8'(i)));
            tick();
        end
        check_output("stream_end_valid", DW'(bus.m_valid), 0);
        check_output("stream_count", DW'(bus.rd_count), 8);

        // Backpressure: only DEPTH reads may be issued while the consumer stalls
        bus.m_ready = 1'b0;
        base = rd_issued;
        for (int i = 1; i <= 5; i++) push(w(8'(8'h10 + i)));
        repeat (10) tick();
        check_output("bp_reads", DW'(rd_issued - base), 3);
        check_output("bp_valid", DW'(bus.m_valid), 1);
        check_output("bp_hold_data", bus.m_data, w(8'h11));
        check_output("bp_rden", DW'(bus.fifo_rden), 0);
        bus.m_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            check_output("bp_out_valid", DW'(bus.m_valid), 1);
            check_output("bp_out_data", bus.m_data, w(8'(8'h10 + i)));
            tick();
        end
        check_output("bp_end_valid", DW'(bus.m_valid), 0);
        check_output("bp_count", DW'(bus.rd_count), 13);

        // Empty boundary with ALMOSTEMPTY high: reads on alternate cycles
        bus.fifo_almostempty = 1'b1;
        base     = rd_issued;
        adj_base = adj_reads;
        push(w(8'h21));
        push(w(8'h22));
        #1;
        check_output("ae_rden_e0", DW'(bus.fifo_rden), 1);
        tick();
        check_output("ae_rden_e1", DW'(bus.fifo_rden), 0);
        tick();
        check_output("ae_rden_e2", DW'(bus.fifo_rden), 1);
        check_output("ae_valid_e2", DW'(bus.m_valid), 1);
        check_output("ae_data_e2", bus.m_data, w(8'h21));
        tick();
        check_output("ae_valid_e3", DW'(bus.m_valid), 0);
        tick();
        check_output("ae_valid_e4", DW'(bus.m_valid), 1);
        check_output("ae_data_e4", bus.m_data, w(8'h22));
        tick();
        check_output("ae_valid_e5", DW'(bus.m_valid), 0);
        check_output("ae_count", DW'(bus.rd_count), 15);
        check_output("ae_reads", DW'(rd_issued - base), 2);
        check_output("ae_adjacent", DW'(adj_reads - adj_base), 0);
        bus.fifo_almostempty = 1'b0;

        // Flush with 3 words buffered and 5 still in the FIFO
        bus.m_ready = 1'b0;
        base = rd_issued;
        for (int i = 1; i <= 8; i++) push(w(8'(8'h30 + i)));
        repeat (6) tick();
        check_output("fl_pre_valid", DW'(bus.m_valid), 1);
        check_output("fl_pre_data", bus.m_data, w(8'h31));
        check_output("fl_pre_reads", DW'(rd_issued - base), 3);
        bus.flush = 1'b1;
        tick();
        bus.flush   = 1'b0;
        bus.m_ready = 1'b1;
        check_output("fl_valid_drop", DW'(bus.m_valid), 0);
        check_output("fl_busy", DW'(bus.busy), 1);
        base = rd_issued;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_output("fl_no_valid", DW'(bus.m_valid), 0);
        end
        check_output("fl_drain_reads", DW'(rd_issued - base), 5);
        check_output("fl_busy_end", DW'(bus.busy), 0);
        check_output("fl_count", DW'(bus.rd_count), 15);
        check_output("fl_fifo_empty", DW'(fifo_cnt), 0);

        // Reset while a read is in flight
        push(w(8'h41));
        #1;
        check_output("mr_rden", DW'(bus.fifo_rden), 1);
        tick();
        check_output("mr_inflight_valid", DW'(bus.m_valid), 0);
        rst = 1'b1;
        #1;
        check_output("mr_rden_rst", DW'(bus.fifo_rden), 0);
        check_output("mr_valid_rst", DW'(bus.m_valid), 0);
        check_output("mr_data_rst", bus.m_data, 0);
        check_output("mr_busy_rst", DW'(bus.busy), 1);
        check_output("mr_count_rst", DW'(bus.rd_count), 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_output("mr_no_stale_valid", DW'(bus.m_valid), 0);
            check_output("mr_no_stale_data", bus.m_data, 0);
        end
        check_output("mr_busy_end", DW'(bus.busy), 0);
        check_output("no_read_when_empty", DW'(bad_reads), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
